// File: rtl/env_measure_pkg.sv
// env_measure_pkg: shared alarm state type, default parameters and clamp helper
package env_measure_pkg;
  typedef enum logic [1:0] {ALM_OK, ALM_HIGH, ALM_LOW} alarm_state_t;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DW = 8;
  localparam int DEF_STEP_W = 4;
  localparam int DEF_RST_VAL = 50;
  localparam int DEF_MIN_VAL = 0;
  localparam int DEF_MAX_VAL = 100;
  localparam int DEF_HYST = 3;
  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lo, input logic [31:0] hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
endpackage

// File: rtl/env_measure_slice.sv
// env_measure_slice: one channel value register with saturating step/load and hysteretic alarm FSM
module env_measure_slice
  import env_measure_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int STEP_W = DEF_STEP_W,
  parameter int RST_VAL = DEF_RST_VAL,
  parameter int MIN_VAL = DEF_MIN_VAL,
  parameter int MAX_VAL = DEF_MAX_VAL,
  parameter int HYST = DEF_HYST
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              inc_en,
  input  logic              dec_en,
  input  logic [STEP_W-1:0] step,
  input  logic              load_en,
  input  logic [DW-1:0]     load_val,
  input  logic [DW-1:0]     thr_hi,
  input  logic [DW-1:0]     thr_lo,
  output logic [DW-1:0]     val,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic              alarm_hi,
  output logic              alarm_lo,
  output logic              alarm_evt
);
  localparam logic [DW-1:0] MIN_V = DW'(MIN_VAL);
  localparam logic [DW-1:0] MAX_V = DW'(MAX_VAL);
  localparam logic [DW-1:0] RST_V = DW'(RST_VAL);
  localparam logic [DW-1:0] HYST_V = DW'(HYST);
  alarm_state_t state, state_nxt;
  logic [DW-1:0] val_nxt, rel_hi, rel_lo;
  logic [DW:0] sum, diff, lo_sum;
  always_comb begin
    sum = {1'b0, val} + (DW+1)'(step);
    diff = {1'b0, val} - (DW+1)'(step);
    val_nxt = load_en ? DW'(clamp(32'(load_val), 32'(MIN_VAL), 32'(MAX_VAL)))
            : (inc_en && dec_en) ? val
            : inc_en ? DW'(clamp(32'(sum), 32'(MIN_VAL), 32'(MAX_VAL)))
            : dec_en ? (diff[DW] ? MIN_V : DW'(clamp(32'(diff), 32'(MIN_VAL), 32'(MAX_VAL))))
            : val;
  end
  always_comb begin
    lo_sum = {1'b0, thr_lo} + {1'b0, HYST_V};
    rel_hi = thr_hi < HYST_V ? '0 : thr_hi - HYST_V;
    rel_lo = lo_sum[DW] ? '1 : lo_sum[DW-1:0];
    state_nxt = state == ALM_OK ? (val > thr_hi ? ALM_HIGH : val < thr_lo ? ALM_LOW : ALM_OK)
              : state == ALM_HIGH ? (val < thr_lo ? ALM_LOW : val <= rel_hi ? ALM_OK : ALM_HIGH)
              : (val > thr_hi ? ALM_HIGH : val >= rel_lo ? ALM_OK : ALM_LOW);
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      val <= RST_V;
      state <= ALM_OK;
      alarm_evt <= 1'b0;
    end else begin
      val <= val_nxt;
      state <= state_nxt;
      alarm_evt <= state_nxt != state;
    end
  assign sat_hi = val == MAX_V;
  assign sat_lo = val == MIN_V;
  assign alarm_hi = state == ALM_HIGH;
  assign alarm_lo = state == ALM_LOW;
endmodule

// File: rtl/env_measure_mc.sv
// env_measure_mc: multi-channel environmental value tracker with per-channel threshold alarms
module env_measure_mc
  import env_measure_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DW = DEF_DW,
  parameter int STEP_W = DEF_STEP_W,
  parameter int RST_VAL = DEF_RST_VAL,
  parameter int MIN_VAL = DEF_MIN_VAL,
  parameter int MAX_VAL = DEF_MAX_VAL,
  parameter int HYST = DEF_HYST
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [NUM_CH-1:0]    inc_en,
  input  logic [NUM_CH-1:0]    dec_en,
  input  logic [STEP_W-1:0]    step,
  input  logic [NUM_CH-1:0]    load_en,
  input  logic [NUM_CH*DW-1:0] load_val,
  input  logic [DW-1:0]        thr_hi,
  input  logic [DW-1:0]        thr_lo,
  output logic [NUM_CH*DW-1:0] real_time_val,
  output logic [NUM_CH-1:0]    sat_hi,
  output logic [NUM_CH-1:0]    sat_lo,
  output logic [NUM_CH-1:0]    alarm_hi,
  output logic [NUM_CH-1:0]    alarm_lo,
  output logic [NUM_CH-1:0]    alarm_evt
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    env_measure_slice #(
      .DW(DW), .STEP_W(STEP_W), .RST_VAL(RST_VAL),
      .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .HYST(HYST)
    ) u_slice (
      .pclk(pclk),
      .presetn(presetn),
      .inc_en(inc_en[i]),
      .dec_en(dec_en[i]),
      .step(step),
      .load_en(load_en[i]),
      .load_val(load_val[i*DW +: DW]),
      .thr_hi(thr_hi),
      .thr_lo(thr_lo),
      .val(real_time_val[i*DW +: DW]),
      .sat_hi(sat_hi[i]),
      .sat_lo(sat_lo[i]),
      .alarm_hi(alarm_hi[i]),
      .alarm_lo(alarm_lo[i]),
      .alarm_evt(alarm_evt[i])
    );
  end
endmodule

// File: doc/env_measure_mc.md
Name: env_measure_mc

Overview:
Multi-channel, parametrised successor of the single-channel humidity counter. Each channel holds a real-time environmental value (humidity or temperature) that is stepped up or down by a programmable amount, loaded directly for calibration, and saturated at configured limits. Each channel also runs a threshold alarm state machine with hysteresis. Sits between the stimulus/actuator logic and the APB register/controller layer in the temp_hum subsystem.

Parameters:
NUM_CH, 2, number of independent channels
DW, 8, value width in bits
STEP_W, 4, width of step magnitude
RST_VAL, 50, per-channel value after reset (MIN_VAL <= RST_VAL <= MAX_VAL)
MIN_VAL, 0, lower saturation limit
MAX_VAL, 100, upper saturation limit
HYST, 3, alarm release hysteresis in value LSBs

Ports:
pclk  input  1  clock
presetn  input  1  reset, asynchronous, active-low
inc_en  input  NUM_CH  per-channel increment request
dec_en  input  NUM_CH  per-channel decrement request
step  input  STEP_W  step magnitude shared by all channels; 0 means hold
load_en  input  NUM_CH  per-channel direct load
load_val  input  NUM_CH*DW  per-channel load data, channel i at [i*DW +: DW]
thr_hi  input  DW  high alarm threshold, shared
thr_lo  input  DW  low alarm threshold, shared
real_time_val  output  NUM_CH*DW  per-channel current value
sat_hi  output  NUM_CH  value == MAX_VAL
sat_lo  output  NUM_CH  value == MIN_VAL
alarm_hi  output  NUM_CH  channel in HIGH alarm
alarm_lo  output  NUM_CH  channel in LOW alarm
alarm_evt  output  NUM_CH  one-cycle pulse on any alarm state change

Behaviour:
- Reset is asynchronous and active-low on presetn. Under reset: every value = RST_VAL, sat_hi/sat_lo reflect RST_VAL, alarm state OK, alarm_hi = alarm_lo = alarm_evt = 0. Reset mid-operation aborts immediately and ignores requests in flight.
- Value update occurs every pclk rising edge, with this priority:
  - load_en: value <= clamp(load_val) to [MIN_VAL, MAX_VAL].
  - else inc_en & dec_en both set: hold.
  - else inc_en: value <= min(value + step, MAX_VAL).
  - else dec_en: value <= max(value - step, MIN_VAL).
  - else hold.
- Arithmetic is done in DW+1 bits, so no wrap-around is ever visible. Underflow below MIN_VAL and overflow above MAX_VAL both clamp.
- Latency: value visible 1 cycle after the request. sat_hi/sat_lo are combinational from the registered value.
- Alarm FSM per channel, states OK, HIGH, LOW. It evaluates the registered value, so the alarm output lags the value by 1 cycle.
  - OK -> HIGH when value > thr_hi.
  - OK -> LOW when value < thr_lo.
  - HIGH -> OK when value <= thr_hi - HYST. If thr_hi < HYST the release point is 0.
  - HIGH -> LOW when value < thr_lo; this has priority over release.
  - LOW -> OK when value >= thr_lo + HYST, saturated at 2^DW-1.
  - LOW -> HIGH when value > thr_hi.
  - If thr_lo > thr_hi (misconfigured), HIGH has priority over LOW from OK.
- alarm_hi / alarm_lo are registered decodes of the state. alarm_evt is registered and high for exactly 1 cycle on the cycle the state register changes.
- Threshold changes take effect on the next evaluation; no re-arm is required.
- Channels are fully independent; activity on one never affects another.

Decomposition:
- Package env_measure_pkg holds:
  - alarm_state_t enum {ALM_OK, ALM_HIGH, ALM_LOW}
  - default parameter constants (DW, RST_VAL, MIN_VAL, MAX_VAL, HYST)
  - a clamp function for DW+1-bit intermediates
- Sub-module env_measure_slice implements one channel (value register plus alarm FSM). The top generates NUM_CH instances and handles the flatten/unflatten of buses.

Test Plan (NUM_CH=2, DW=8, RST_VAL=50, MIN=0, MAX=100, HYST=3):
1. Reset release -> both values 50, sat_*=0, alarm_*=0, alarm_evt=0.
2. ch0 inc_en for 3 cycles with step=1 -> ch0 = 51, 52, 53 on successive cycles, ch1 stays 50. Then inc_en & dec_en with step=5 -> ch0 holds 53.
3. Load ch0 = 95, inc with step=10 -> 100, sat_hi=1. Load ch1 = 5, dec with step=10 -> 0, sat_lo=1. Load 200 -> clamps to 100.
4. thr_hi=70, thr_lo=20. Load ch0 = 71 -> alarm_hi=1 and alarm_evt 1-cycle pulse the cycle after. Load 68 -> alarm_hi stays 1. Load 67 -> alarm_hi=0 with evt pulse.
5. ch1 in HIGH (value 80), load 10 -> goes directly to LOW: alarm_lo=1, alarm_hi=0, single evt pulse. Load 22 -> still LOW. Load 23 -> OK.
6. Same-cycle load_en and inc_en on ch0 (load 40, step 5) -> 40. Assert presetn low mid-stream, asynchronously to pclk -> value 50 and alarms clear immediately, without waiting for a clock edge.
